// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - request inputs and lamp/status outputs of the phase scheduler
interface traffic_phase_scheduler_if;
    logic       side_req;
    logic       ped_req;
    logic       emerg_req;
    logic [2:0] light_main;
    logic [2:0] light_side;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output side_req, ped_req, emerg_req,
        input  light_main, light_side, walk, ped_ack, phase
    );

    modport slave (
        input  side_req, ped_req, emerg_req,
        output light_main, light_side, walk, ped_ack, phase
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road intersection phase sequencer with pedestrian and emergency handling
module traffic_phase_scheduler #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int T_MAIN_MIN = 7,
    parameter int T_YEL      = 2,
    parameter int T_ALLRED   = 1,
    parameter int T_SIDE     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    traffic_phase_scheduler_if.slave    bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = 8;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MAIN_LAST   = TW'(T_MAIN_MIN - 1);
    localparam logic [TW-1:0] YEL_LAST    = TW'(T_YEL - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] SIDE_LAST   = TW'(T_SIDE - 1);

    localparam logic [2:0] MAIN_G   = 3'd0;
    localparam logic [2:0] MAIN_Y   = 3'd1;
    localparam logic [2:0] ALL_RED1 = 3'd2;
    localparam logic [2:0] SIDE_G   = 3'd3;
    localparam logic [2:0] SIDE_Y   = 3'd4;
    localparam logic [2:0] ALL_RED2 = 3'd5;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [TW-1:0] tcnt;
    logic          ped_pending;
    logic          walk_en;
    logic          ped_ack_r;
    logic          tick;
    logic          side_start;
    logic          serve;

    assign tick       = (presc == PRESC_LAST);
    // A request arriving on the very edge that opens SIDE_G is still served.
    assign side_start = (state == ALL_RED1) && (state_nxt == SIDE_G);
    assign serve      = ped_pending | bus.ped_req;

    // Next phase; emergency wins over side/ped requests wherever it is allowed to act.
    always_comb begin
        state_nxt = state;
        case (state)
            MAIN_G:   if (tick && tcnt == MAIN_LAST && (bus.side_req || ped_pending) && !bus.emerg_req)
                          state_nxt = MAIN_Y;
            MAIN_Y:   if (tick && tcnt == YEL_LAST) state_nxt = ALL_RED1;
            ALL_RED1: if (tick && tcnt == ALLRED_LAST) state_nxt = bus.emerg_req ? MAIN_G : SIDE_G;
            SIDE_G:   if (bus.emerg_req || (tick && tcnt == SIDE_LAST)) state_nxt = SIDE_Y;
            SIDE_Y:   if (tick && tcnt == YEL_LAST) state_nxt = ALL_RED2;
            ALL_RED2: if (tick && tcnt == ALLRED_LAST) state_nxt = MAIN_G;
            default:  state_nxt = MAIN_G;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MAIN_G;
        else     state <= state_nxt;
    end

    // Prescaler and per-phase tick counter restart on every phase change; main green saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (state_nxt != state) begin
            presc <= '0;
            tcnt  <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && !(state == MAIN_G && tcnt == MAIN_LAST))
                tcnt <= tcnt + TW'(1);
        end
    end

    // Pedestrian latch: pending until consumed when side green opens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
            walk_en     <= 1'b0;
            ped_ack_r   <= 1'b0;
        end else begin
            ped_ack_r <= side_start & serve;
            if (side_start) begin
                walk_en     <= serve;
                ped_pending <= 1'b0;
            end else begin
                if (bus.ped_req) ped_pending <= 1'b1;
                if (state == SIDE_G && state_nxt != SIDE_G) walk_en <= 1'b0;
            end
        end
    end

    // Lamp decode straight from the registered phase.
    always_comb begin
        bus.light_main = LAMP_RED;
        bus.light_side = LAMP_RED;
        case (state)
            MAIN_G:  bus.light_main = LAMP_GREEN;
            MAIN_Y:  bus.light_main = LAMP_YELLOW;
            SIDE_G:  bus.light_side = LAMP_GREEN;
            SIDE_Y:  bus.light_side = LAMP_YELLOW;
            default: ;
        endcase
    end

    assign bus.walk    = walk_en && (state == SIDE_G);
    assign bus.ped_ack = ped_ack_r;
    assign bus.phase   = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;
    localparam int TD  = 4;
    localparam int TMM = 7;
    localparam int TY  = 2;
    localparam int TAR = 1;
    localparam int TS  = 5;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] lm;
        logic [2:0] ls;
        logic       w;
        logic       a;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t expq[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [2:0] lm_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ls_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_phase, m_el;
    bit m_pend, m_wen, m_ack;
    bit sr, pr, er, rst_req;
    int wcnt, acnt;
    int cur_ph, run_len;
    int last_len [8];

    function automatic void model_reset();
        m_phase = 0; m_el = 0; m_pend = 0; m_wen = 0; m_ack = 0;
    endfunction

    // Durations expressed as elapsed clk cycles since phase entry.
    function automatic void model_step(bit s, bit p, bit e);
        int nxt;
        int el1;
        nxt   = m_phase;
        el1   = m_el + 1;
        m_ack = 0;
        case (m_phase)
            0: if (el1 % TD == 0 && el1 >= TMM * TD && (s || m_pend) && !e) nxt = 1;
            1: if (el1 == TY * TD) nxt = 2;
            2: if (el1 == TAR * TD) nxt = e ? 0 : 3;
            3: if (e || el1 == TS * TD) nxt = 4;
            4: if (el1 == TY * TD) nxt = 5;
            default: if (el1 == TAR * TD) nxt = 0;
        endcase
        if (m_phase == 2 && nxt == 3) begin
            m_wen  = m_pend || p;
            m_ack  = m_wen;
            m_pend = 0;
        end else if (p) begin
            m_pend = 1;
        end
        m_el    = (nxt == m_phase) ? el1 : 0;
        m_phase = nxt;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.ph = 3'(m_phase);
        e.lm = lm_tab[m_phase];
        e.ls = ls_tab[m_phase];
        e.w  = m_wen && (m_phase == 3);
        e.a  = m_ack;
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(string name);
        check(name, int'({bus.phase, bus.light_main, bus.light_side, bus.walk, bus.ped_ack}),
              int'({3'b000, 3'b001, 3'b100, 2'b00}));
    endtask

    // One clock of stimulus: observe the previous edge, drive inputs, queue the expectation.
    task automatic step();
        @(negedge clk);
        #1;
        if (bus.walk) wcnt++;
        if (bus.ped_ack) acnt++;
        if (int'(bus.phase) == cur_ph) run_len++;
        else begin
            last_len[cur_ph] = run_len;
            cur_ph  = int'(bus.phase);
            run_len = 1;
        end
        rst = rst_req;
        bus.side_req  = sr;
        bus.ped_req   = pr;
        bus.emerg_req = er;
        if (rst_req) model_reset();
        else         model_step(sr, pr, er);
        expq.push_back(model_out());
    endtask

    task automatic reset_dut();
        rst_req = 1; sr = 0; pr = 0; er = 0;
        repeat (2) step();
        rst_req = 0;
    endtask

    task automatic run_until(int ph, string tag);
        int k;
        k = 0;
        while (m_phase != ph && k < 400) begin
            step();
            k++;
        end
        if (m_phase != ph) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s: timeout waiting for phase %0d, model phase %0d", tag, ph, m_phase);
        end
    endtask

    // Monitor: compare every DUT output set against the queued expectation.
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            mon_e = expq.pop_front();
            n_assert++;
            if ({bus.phase, bus.light_main, bus.light_side, bus.walk, bus.ped_ack} !== mon_e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got phase=%0d main=%b side=%b walk=%b ack=%b, expected phase=%0d main=%b side=%b walk=%b ack=%b",
                         $time, bus.phase, bus.light_main, bus.light_side, bus.walk, bus.ped_ack,
                         mon_e.ph, mon_e.lm, mon_e.ls, mon_e.w, mon_e.a);
            end
        end
    end

    initial begin
        int k;
        bus.side_req = 0; bus.ped_req = 0; bus.emerg_req = 0;
        sr = 0; pr = 0; er = 0; wcnt = 0; acnt = 0; cur_ph = 0; run_len = 0;
        for (int i = 0; i < 8; i++) last_len[i] = 0;
        #1 rst = 1;
        #1 check_reset("reset_initial");
        rst_req = 1;
        repeat (3) step();

        // Idle: no requests for 300 cycles.
        rst_req = 0; wcnt = 0; acnt = 0;
        repeat (300) step();
        check("idle_walk_cycles", wcnt, 0);
        check("idle_ack_cycles", acnt, 0);
        check("idle_phase", int'(bus.phase), 0);

        // Side request held: nominal phase durations.
        reset_dut();
        sr = 1; wcnt = 0;
        repeat (150) step();
        check("side_len_main_g", last_len[0], 28);
        check("side_len_main_y", last_len[1], 8);
        check("side_len_allred1", last_len[2], 4);
        check("side_len_side_g", last_len[3], 20);
        check("side_len_side_y", last_len[4], 8);
        check("side_len_allred2", last_len[5], 4);
        check("side_walk_cycles", wcnt, 0);

        // Pedestrian pulse at cycle 5, then another during SIDE_G.
        reset_dut();
        sr = 0; wcnt = 0; acnt = 0;
        repeat (5) step();
        pr = 1; step(); pr = 0;
        run_until(3, "ped_first_side");
        repeat (10) step();
        pr = 1; step(); pr = 0;
        run_until(0, "ped_first_return");
        check("ped_walk_cycles_1", wcnt, 20);
        check("ped_ack_cycles_1", acnt, 1);
        wcnt = 0;
        run_until(3, "ped_second_side");
        run_until(0, "ped_second_return");
        check("ped_main_wait", last_len[0], 28);
        check("ped_walk_cycles_2", wcnt, 20);
        check("ped_ack_cycles_total", acnt, 2);

        // Emergency abort in SIDE_G, then main green held under emergency.
        reset_dut();
        sr = 1;
        step(); pr = 1; step(); pr = 0;
        run_until(3, "emerg_side");
        wcnt = 0;
        repeat (3) step();
        er = 1; step();
        step();
        check("emerg_abort_phase", int'(bus.phase), 4);
        check("emerg_abort_walk", int'(bus.walk), 0);
        check("emerg_side_len", last_len[3], 4);
        check("emerg_walk_cycles", wcnt, 4);
        repeat (120) step();
        check("emerg_hold_phase", int'(bus.phase), 0);
        check("emerg_side_y_len", last_len[4], 8);
        check("emerg_allred2_len", last_len[5], 4);
        er = 0;

        // Pedestrian request on the ALL_RED1 exit edge is served in that SIDE_G.
        reset_dut();
        sr = 1; k = 0;
        while (!(m_phase == 2 && m_el == TAR * TD - 1) && k < 400) begin
            step();
            k++;
        end
        check("coinc_reached_exit", int'(m_phase == 2), 1);
        wcnt = 0; acnt = 0;
        pr = 1; step(); pr = 0;
        run_until(4, "coinc_side");
        check("coinc_walk_cycles", wcnt, 20);
        check("coinc_ack_cycles", acnt, 1);

        // Asynchronous reset mid-SIDE_G with a pending request discards it.
        reset_dut();
        sr = 0;
        pr = 1; step(); pr = 0;
        run_until(3, "async_side");
        repeat (5) step();
        pr = 1; step(); pr = 0;
        @(negedge clk);
        #2;
        rst = 1; rst_req = 1;
        #1;
        check_reset("reset_async_mid_side");
        model_reset();
        expq.push_back(model_out());
        repeat (2) step();
        rst_req = 0; sr = 1; wcnt = 0; acnt = 0;
        repeat (200) step();
        check("async_no_walk", wcnt, 0);
        check("async_no_ack", acnt, 0);

        // Randomized traffic in segments with varying request densities.
        reset_dut();
        for (int seg = 0; seg < 15; seg++) begin
            int ps, pp, pe;
            ps = $urandom_range(0, 100);
            pp = $urandom_range(0, 10);
            pe = $urandom_range(0, 4);
            repeat (200) begin
                sr = ($urandom_range(0, 99) < ps);
                pr = ($urandom_range(0, 99) < pp);
                er = er ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) < pe);
                rst_req = ($urandom_range(0, 599) == 0);
                step();
            end
        end
        rst_req = 0; sr = 0; pr = 0; er = 0;
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, gives clk cycles per timing tick (1 s at 50 MHz).
REQ-002 Parameter T_MAIN_MIN, default 7, gives the minimum main-green ticks.
REQ-003 Parameter T_YEL, default 2, gives the yellow ticks for both roads.
REQ-004 Parameter T_ALLRED, default 1, gives the all-red clearance ticks.
REQ-005 Parameter T_SIDE, default 5, gives the side-green ticks.
REQ-006 The design SHALL have one clock and an asynchronous, active-high reset.
REQ-007 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port side_req, input, 1 bit: side-road vehicle sensor, level, synchronous to clk.
REQ-010 Port ped_req, input, 1 bit: pedestrian button; may be a 1-cycle pulse and is latched internally.
REQ-011 Port emerg_req, input, 1 bit: emergency preemption toward main green, level.
REQ-012 Port light_main, output, 3 bits: main-road lamp; 100 = red, 010 = yellow, 001 = green.
REQ-013 Port light_side, output, 3 bits: side-road lamp, using the same encoding as light_main.
REQ-014 Port walk, output, 1 bit: pedestrian walk lamp.
REQ-015 Port ped_ack, output, 1 bit: 1-cycle pulse when a pedestrian request is served.
REQ-016 Port phase, output, 3 bits: current state encoding.

Function
REQ-017 The design SHALL have the states MAIN_G=0, MAIN_Y=1, ALL_RED1=2, SIDE_G=3, SIDE_Y=4 and ALL_RED2=5; codes 6 and 7 SHALL go to MAIN_G on the next clk.
REQ-018 Prescaler: counts 0..TICK_DIV-1 and pulses tick for 1 cycle at TICK_DIV-1; the prescaler and the phase tick counter SHALL clear on every state change.
REQ-019 A timed state of N ticks SHALL exit on the clk edge where tick=1 and tick count = N-1, so it lasts exactly N*TICK_DIV cycles.
REQ-020 MAIN_G -> MAIN_G SHALL hold for at least T_MAIN_MIN ticks, then go to MAIN_Y on the first tick where (side_req | ped_pending) = 1 and emerg_req = 0; otherwise it stays indefinitely, and the tick counter saturates at T_MAIN_MIN-1.
REQ-021 MAIN_Y -> ALL_RED1 SHALL occur after T_YEL ticks; ALL_RED1 SHALL go to SIDE_G after T_ALLRED ticks, or to MAIN_G instead if emerg_req = 1 on that edge.
REQ-022 SIDE_G -> SIDE_Y SHALL occur after T_SIDE ticks, or on the next clk edge if emerg_req = 1 (early abort).
REQ-023 SIDE_Y -> ALL_RED2 SHALL occur after T_YEL ticks; ALL_RED2 -> MAIN_G SHALL occur after T_ALLRED ticks; emerg_req SHALL NOT shorten SIDE_Y or ALL_RED2.
REQ-024 Lamp decode: MAIN_G gives main 001, side 100; MAIN_Y gives main 010, side 100; SIDE_G gives main 100, side 001; SIDE_Y gives main 100, side 010; both all-red states give main 100, side 100.
REQ-025 All outputs SHALL be a decode of the registered state and flags, with no added latency, and SHALL change on the same edge as phase.
REQ-026 ped_pending SHALL be set by ped_req = 1 and cleared on the ALL_RED1 -> SIDE_G edge.
REQ-027 On the ALL_RED1 -> SIDE_G edge, walk_en SHALL latch (ped_pending | ped_req), so a request arriving on that edge is served, and ped_ack SHALL pulse for 1 cycle if the latched value is 1.
REQ-028 walk SHALL equal walk_en AND (state == SIDE_G), and SHALL drop on the same edge as the SIDE_G exit, including an emergency abort.
REQ-029 A ped_req received outside ALL_RED1's exit edge, including during SIDE_G, SHALL stay pending for the next cycle; ALL_RED1 -> MAIN_G SHALL keep ped_pending unchanged.
REQ-030 Preemption ordering: emerg_req SHALL take precedence over side_req and ped_pending in every state.

Reset
REQ-031 While rst = 1, the design SHALL be forced asynchronously to: state MAIN_G, prescaler 0, tick counter 0, ped_pending 0, walk_en 0.
REQ-032 While rst = 1, outputs SHALL be: light_main 001, light_side 100, walk 0, ped_ack 0, phase 000.
REQ-033 After rst is released, the T_MAIN_MIN timing SHALL start from 0, and an assertion mid-phase SHALL discard all pending requests.

Verification (TICK_DIV=4, all other parameters at default)
REQ-034 No requests for 300 cycles after reset -> phase stays 0, light_main 001, light_side 100, walk and ped_ack never 1.
REQ-035 side_req held high from reset release -> MAIN_G 28, MAIN_Y 8, ALL_RED1 4, SIDE_G 20, SIDE_Y 8, ALL_RED2 4 cycles, then MAIN_G again; walk stays 0.
REQ-036 ped_req 1-cycle pulse at cycle 5 -> same sequence as REQ-035; ped_ack 1 cycle at SIDE_G entry; walk = 1 for exactly 20 cycles.
REQ-037 emerg_req raised at SIDE_G cycle 3 -> SIDE_Y on the next edge with walk falling on the same edge; then SIDE_Y 8 and ALL_RED2 4 cycles; MAIN_G then held while emerg_req = 1 even with side_req = 1.
REQ-038 ped_req during SIDE_G -> after return to MAIN_G, 28 cycles pass and then a second cycle runs with walk = 1; ped_req coincident with the ALL_RED1 exit edge -> walk is served in that same SIDE_G.
REQ-039 rst pulsed asynchronously mid-SIDE_G with ped_pending = 1 -> outputs reset values immediately with no clk edge needed; no walk follows unless ped_req is re-asserted.
